// File: rtl/divider_16by8.sv
// Sequential signed 16/8 divider: restoring division on magnitudes, fixed
// 17-cycle latency from the start edge to the done pulse.
module divider_16by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] input_0,
  input  logic [7:0]  input_1,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        overflow
);

  localparam int unsigned DVD_W = 16;
  localparam int unsigned DSR_W = 8;
  localparam int unsigned REM_W = DSR_W + 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient magnitude
  logic [DSR_W-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic [REM_W-1:0] rem_q, rem_d;     // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_n_q, neg_n_d; // dividend sign
  logic             neg_d_q, neg_d_d; // divisor sign
  logic             dz_q, dz_d;       // divisor was zero
  logic             ovf_q, ovf_d;     // -32768 / -1
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DSR_W-1:0] rmd_q, rmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dzo_q, dzo_d;
  logic             ovo_q, ovo_d;

  // One extra headroom bit keeps the borrow of the trial subtraction visible.
  logic [REM_W:0]   rem_shift;
  logic [REM_W:0]   trial;

  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dzo_q;
  assign overflow  = ovo_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_n_q <= 1'b0;
      neg_d_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_n_q <= neg_n_d;
      neg_d_q <= neg_d_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
    end
  end

  // Next-state, restoring-division step and sign/special-case fix-up.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_n_d   = neg_n_q;
    neg_d_d   = neg_d_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    quot_d    = quot_q;
    rmd_d     = rmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dzo_d     = dzo_q;
    ovo_d     = ovo_q;
    rem_shift = {rem_q, dvd_q[DVD_W-1]};
    trial     = rem_shift - {2'b00, dsr_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_n_d = input_0[DVD_W-1];
          neg_d_d = input_1[DSR_W-1];
          dvd_d   = input_0[DVD_W-1] ? DVD_W'(-input_0) : input_0;
          dsr_d   = input_1[DSR_W-1] ? DSR_W'(-input_1) : input_1;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (input_1 == 8'h00);
          ovf_d   = (input_0 == 16'h8000) && (input_1 == 8'hFF);
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = trial[REM_W] ? rem_shift[REM_W-1:0] : trial[REM_W-1:0];
        dvd_d = {dvd_q[DVD_W-2:0], ~trial[REM_W]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(15)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          quot_d = '0;
          rmd_d  = '0;
          dzo_d  = 1'b1;
          ovo_d  = 1'b0;
        end else if (ovf_q) begin
          quot_d = 16'h7FFF;
          rmd_d  = '0;
          dzo_d  = 1'b0;
          ovo_d  = 1'b1;
        end else begin
          quot_d = (neg_n_q ^ neg_d_q) ? DVD_W'(-dvd_q) : dvd_q;
          rmd_d  = neg_n_q ? DSR_W'(-rem_q[DSR_W-1:0]) : rem_q[DSR_W-1:0];
          dzo_d  = 1'b0;
          ovo_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/divider_16by8.md
# divider_16by8

Sequential signed two's-complement divider: a 16-bit dividend divided by an 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder. It is the inverse-direction companion to the 8×8 signed multiplier in the FFT datapath. It is used to normalise and rescale products (for example, undoing a twiddle-factor gain) after multiplication. It uses the same start-pulse, multi-cycle style as the multiplier, and adds explicit busy/done handshake signals.

## Interface

Parameters: none. Widths are fixed.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- input_0  in  16  dividend, signed two's complement
- input_1  in  8  divisor, signed two's complement
- quotient  out  16  signed quotient, truncated toward zero
- remainder  out  8  signed remainder; sign follows dividend
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; results valid from this cycle onward
- div_zero  out  1  divisor was 0; valid with done
- overflow  out  1  quotient not representable; valid with done

## Operation

- States:
  - IDLE: wait for start.
  - CALC: 16 iterations of restoring division on magnitudes.
  - FIX: apply signs and special cases, then register the outputs.
  - FIX always returns to IDLE.
- IDLE, start=1:
  - Latch the signs of input_0 and input_1.
  - Latch |input_0| into a 16-bit unsigned register and |input_1| into an 8-bit unsigned register.
  - Clear the 9-bit partial remainder and the iteration counter.
  - Go to CALC.
  - Operands may change after this edge.
- CALC, one edge per iteration:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Subtract the divisor magnitude. If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - After the 16th iteration, go to FIX.
- FIX, result rules:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - Invariant: input_0 = quotient·input_1 + remainder, and |remainder| < |input_1|.
- FIX, special cases:
  - Divisor = 0: quotient=16'h0000, remainder=8'h00, div_zero=1, overflow=0.
  - Dividend = 16'h8000 and divisor = 8'hFF: quotient=16'h7FFF (saturated), remainder=8'h00, overflow=1.
  - Both special cases are resolved in FIX. The full CALC length is still taken, so latency is constant.
- Outputs quotient, remainder, div_zero and overflow hold their values until the next FIX.
- start while busy=1 is ignored; no queueing.
- Reset (any state, including mid-CALC): at the next edge, state=IDLE and all outputs are 0. The division in flight is discarded and done is not pulsed.

## Timing

- Reset values: quotient=0, remainder=0, busy=0, done=0, div_zero=0, overflow=0.
- start sampled high at edge N (while IDLE):
  - busy=1 from edge N.
  - CALC iterations occur at edges N+1 … N+16.
  - FIX at edge N+17 registers the results. At that same edge busy→0 and done→1.
  - done→0 at edge N+18.
- Latency: 17 cycles from the start edge to done; the value is fixed and independent of the data.
- Throughput: a start sampled at edge N+18 (the cycle when done is high) is accepted. Back-to-back divisions therefore issue every 18 cycles.
- done is never high for more than one cycle. busy and done are never high together.
- start held high continuously produces a new division every 18 cycles.

## Test plan

- Basic: 100 / 7 → quotient=16'h000E, remainder=8'h02, done exactly 17 edges after the start edge, busy high for 17 cycles.
- Signed: each case below gives the stated quotient and remainder, with flags 0.
  - -100 / 7 (16'hFF9C, 8'h07) → quotient=16'hFFF2, remainder=8'hFE.
  - 100 / -7 → quotient=16'hFFF2, remainder=8'h02.
  - -30 / 6 (16'hFFE2, 8'h06) → quotient=16'hFFFB, remainder=8'h00.
- Special cases:
  - 1234 / 0 → div_zero=1, quotient=0, remainder=0.
  - 16'h8000 / 8'hFF → overflow=1, quotient=16'h7FFF.
  - 16'h8000 / 8'h80 → quotient=16'h0100, no flags.
- Handshake: pulse start again 5 cycles after the first start → ignored, and only one done occurs. Then assert start in the done cycle → second result arrives 17 cycles later.
- Reset mid-operation: assert rst for 1 cycle at iteration 8 → all outputs 0 and no done pulse. A fresh start afterwards gives a correct result.
- Random: 1000 random operand pairs, checked against a behavioural model using the invariant and the sign rules.
